sram_like_slave: RTL and testbench

Responder end of the core's SRAM-like bus (req / wr / size / addr / wdata → addr_ok / data_ok / rdata). It is the memory the pipeline's instruction or data port talks to in standalone core simulation, and the behavioural target the AXI bridge's SRAM-like side is checked against. It accepts requests, commits stores at acceptance and returns in-order data_ok responses after a fixed latency. Up to DEPTH requests may be in flight.

---
 rtl/sram_like_pkg.sv | 28 ++
 rtl/sram_like_resp_queue.sv | 70 +++++++
 rtl/sram_like_slave.sv | 100 ++++++++++
 tb/tb_sram_like_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg
// Shared definitions for the SRAM-like bus responder:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : encodings of the bus size field
//   resp_entry_t                      : one in-flight response (load flag, captured word, countdown)
//   byte_en(size, lane)               : 4-bit lane-enable mask for a store
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
    logic [2:0]  cnt;
  } resp_entry_t;

  // Misaligned halves are not rejected: the shift only looks at lane[1],
  // so a half at lane 1 or 3 lands on the lower/upper half respectively.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << lane;
      SIZE_HALF: byte_en = 4'b0011 << {lane[1], 1'b0};
      default:   byte_en = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// sram_like_resp_queue
// DEPTH-entry circular FIFO of pending responses. Each entry carries a
// countdown loaded with LAT-1 on push; the head is due once its countdown
// reaches zero.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   push               : write a new entry at the tail
//   push_is_load       : entry is a load response
//   push_rdata         : word captured for a load
//   pop                : retire the head (caller only pops a due head)
//   head_is_load       : head entry load flag
//   head_rdata         : head entry captured word
//   head_due           : queue non-empty and head countdown expired
//   count              : number of occupied entries
module sram_like_resp_queue
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_is_load,
  input  logic [31:0]                push_rdata,
  input  logic                       pop,
  output logic                       head_is_load,
  output logic [31:0]                head_rdata,
  output logic                       head_due,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  resp_entry_t       entries [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  resp_entry_t       head;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Every slot ticks; empty slots are overwritten on push so their
      // countdown value is irrelevant.
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].cnt != 3'd0) entries[i].cnt <= entries[i].cnt - 3'd1;
      end
      // When full with a retiring head, wr_ptr == rd_ptr and the push
      // overwrites the slot being popped.
      if (push) begin
        entries[wr_ptr] <= '{is_load: push_is_load, rdata: push_rdata, cnt: CNT_INIT};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head         = entries[rd_ptr];
  assign head_is_load = head.is_load;
  assign head_rdata   = head.rdata;
  assign head_due     = (count != '0) && (head.cnt == 3'd0);

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave
// Responder end of the SRAM-like bus. Stores commit to the RAM at
// acceptance, loads capture the pre-write word at acceptance, and responses
// come back in order after LAT cycles with up to DEPTH in flight.
// Optional build macro: SRAM_LIKE_BACKPRESSURE_EN adds a 16-bit LFSR that
// drops addr_ok about one cycle in four.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   req     : request valid, held until addr_ok
//   wr      : 1 = store, 0 = load
//   size    : 0 byte, 1 half, 2/3 word
//   addr    : byte address; bits [MEM_AW+1:2] index the RAM
//   wdata   : lane-aligned store data
//   addr_ok : request accepted this cycle
//   data_ok : response pulse for the oldest in-flight request
//   rdata   : load word for a load response, 0 otherwise
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int LAT    = 2,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] word_idx;
  logic [3:0]        wr_be;
  logic [31:0]       rd_word;
  logic              bp_stall;
  logic [CW-1:0]     count;
  logic              head_due;
  logic              head_is_load;
  logic [31:0]       head_rdata;
  logic              addr_unused;

  assign word_idx    = addr[MEM_AW+1:2];
  assign addr_unused = ^{addr[31:MEM_AW+2]};
  assign wr_be       = byte_en(size, addr[1:0]);
  assign rd_word     = mem[word_idx];

  // Gated by rst so a reset cycle never shows a stale head as a response.
  assign data_ok = head_due && !rst;
  assign addr_ok = req && !rst && ((count < DEPTH_C) || data_ok) && !bp_stall;
  assign rdata   = (data_ok && head_is_load) ? head_rdata : 32'h0;

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (addr_ok && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  sram_like_resp_queue #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (addr_ok),
    .push_is_load (!wr),
    .push_rdata   (rd_word),
    .pop          (data_ok),
    .head_is_load (head_is_load),
    .head_rdata   (head_rdata),
    .head_due     (head_due),
    .count        (count)
  );

`ifdef SRAM_LIKE_BACKPRESSURE_EN
  // Fibonacci LFSR, taps 16,14,13,11.
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_stall = (lfsr[1:0] == 2'b00);
`else
  assign bp_stall = 1'b0;
`endif

endmodule

// File: tb/tb_sram_like_slave.sv
module tb_sram_like_slave;

  localparam int ND = 3;   // instance 0: LAT=2, 1: LAT=4, 2: LAT=1; all DEPTH=2

  logic        clk = 1'b0;
  logic        rst     [ND];
  logic        req     [ND];
  logic        wr      [ND];
  logic [1:0]  size    [ND];
  logic [31:0] addr    [ND];
  logic [31:0] wdata   [ND];
  logic        addr_ok [ND];
  logic        data_ok [ND];
  logic [31:0] rdata   [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    sram_like_slave #(.MEM_AW(12), .LAT(L), .DEPTH(2)) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .req     (req[g]),
      .wr      (wr[g]),
      .size    (size[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .addr_ok (addr_ok[g]),
      .data_ok (data_ok[g]),
      .rdata   (rdata[g])
    );
  end

  typedef struct {
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        exp_ok, exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t v(input logic r, input logic q, input logic w, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic eo, input logic ed, input logic [31:0] er);
    vec_t t;
    t.rst = r; t.req = q; t.wr = w; t.size = s; t.addr = a; t.wdata = wd;
    t.exp_ok = eo; t.exp_dok = ed; t.exp_rdata = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 ns later.
  task automatic drive(input int d, input logic r, input logic q, input logic w,
                       input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rst[d] = r; req[d] = q; wr[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
    #1;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  // Random traffic on instance 0 against a byte-accurate memory model.
  task automatic random_test();
    logic [31:0] mdl [16];
    logic [31:0] expq [$];
    logic        have;
    logic        pw;
    logic [1:0]  ps, poff;
    logic [3:0]  pidx, be;
    logic [31:0] pwd, paddr, e;
    int          acc, stalls, reqcyc, cyc;
    have = 1'b0; acc = 0; stalls = 0; reqcyc = 0; cyc = 0;
    pw = 1'b0; ps = 2'd0; poff = 2'd0; pidx = 4'd0; pwd = 32'h0; paddr = 32'h0;
    while (acc < 1000 && cyc < 20000) begin
      if (!have) begin
        if (acc < 16) begin
          pw = 1'b1; ps = 2'd2; pidx = 4'(acc); poff = 2'd0;
        end else begin
          pw = 1'($urandom_range(0, 1)); ps = 2'($urandom_range(0, 3));
          pidx = 4'($urandom_range(0, 15)); poff = 2'($urandom_range(0, 3));
        end
        pwd   = $urandom;
        paddr = {18'($urandom), 14'(14'h800 + 14'(pidx) * 14'd4 + 14'(poff))};
        have  = 1'b1;
      end
      drive(0, 1'b0, 1'b1, pw, ps, paddr, pwd);
      cyc++; reqcyc++;
      if (data_ok[0]) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd.spurious_data_ok: got data_ok with no request outstanding");
        end else begin
          e = expq.pop_front();
          chk("rnd.rdata", rdata[0], e);
        end
      end
      if (addr_ok[0]) begin
        if (pw) begin
          case (ps)
            2'd0:    be = 4'b0001 << poff;
            2'd1:    be = poff[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          for (int b = 0; b < 4; b++) if (be[b]) mdl[pidx][8*b +: 8] = pwd[8*b +: 8];
          expq.push_back(32'h0);
        end else begin
          expq.push_back(mdl[pidx]);
        end
        acc++; have = 1'b0;
      end else begin
        stalls++;
      end
    end
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      idle(0);
      if (data_ok[0]) begin
        e = expq.pop_front();
        chk("rnd.drain_rdata", rdata[0], e);
      end
    end
    chk("rnd.accepted", acc, 1000);
    chk("rnd.all_responded", expq.size(), 0);
`ifdef SRAM_LIKE_BACKPRESSURE_EN
    chk("rnd.stall_rate_20_30pct",
        32'((stalls * 100 >= reqcyc * 20) && (stalls * 100 <= reqcyc * 30)), 32'd1);
`else
    chk("rnd.no_stalls", stalls, 0);
`endif
  endtask

  initial begin
    logic [12:0] fq_ok;
    logic [12:0] fq_dok;
    logic        q;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst[1] = 1'b0; rst[2] = 1'b0;

`ifndef SRAM_LIKE_BACKPRESSURE_EN
    //         rst  req  wr   size  addr          wdata          ok   dok  rdata
    tbl[0]  = v(1'b1,1'b1,1'b1,2'd2,32'h10,32'hFFFF_FFFF,1'b0,1'b0,32'h0);
    tbl[1]  = v(1'b1,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b0,32'h0);
    tbl[2]  = v(1'b0,1'b1,1'b1,2'd2,32'h10,32'hDEAD_BEEF,1'b1,1'b0,32'h0);
    tbl[3]  = v(1'b0,1'b1,1'b0,2'd2,32'h10,32'h0,        1'b1,1'b0,32'h0);
    tbl[4]  = v(1'b0,1'b1,1'b1,2'd2,32'h20,32'h0,        1'b1,1'b1,32'h0);
    tbl[5]  = v(1'b0,1'b1,1'b1,2'd0,32'h21,32'h0000_AB00,1'b1,1'b1,32'hDEAD_BEEF);
    tbl[6]  = v(1'b0,1'b1,1'b1,2'd1,32'h22,32'h1234_0000,1'b1,1'b1,32'h0);
    tbl[7]  = v(1'b0,1'b1,1'b0,2'd2,32'h20,32'h0,        1'b1,1'b1,32'h0);
    tbl[8]  = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h0);
    tbl[9]  = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h1234_AB00);
    tbl[10] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b0,32'h0);
    tbl[11] = v(1'b0,1'b1,1'b1,2'd2,32'h30,32'h0,        1'b1,1'b0,32'h0);
    tbl[12] = v(1'b0,1'b1,1'b1,2'd1,32'h31,32'hFFFF_FFFF,1'b1,1'b0,32'h0);
    tbl[13] = v(1'b0,1'b1,1'b0,2'd2,32'h30,32'h0,        1'b1,1'b1,32'h0);
    tbl[14] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h0);
    tbl[15] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h0000_FFFF);
    tbl[16] = v(1'b0,1'b1,1'b1,2'd3,32'h40,32'hCAFE_F00D,1'b1,1'b0,32'h0);
    tbl[17] = v(1'b0,1'b1,1'b1,2'd0,32'h43,32'h7700_0000,1'b1,1'b0,32'h0);
    tbl[18] = v(1'b0,1'b1,1'b0,2'd0,32'h41,32'h0,        1'b1,1'b1,32'h0);
    tbl[19] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h0);
    tbl[20] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b1,32'h77FE_F00D);
    tbl[21] = v(1'b0,1'b0,1'b0,2'd0,32'h0, 32'h0,        1'b0,1'b0,32'h0);

    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].rst, tbl[i].req, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d.addr_ok", i), 32'(addr_ok[0]), 32'(tbl[i].exp_ok));
      chk($sformatf("vec%0d.data_ok", i), 32'(data_ok[0]), 32'(tbl[i].exp_dok));
      if (tbl[i].exp_dok || tbl[i].rst)
        chk($sformatf("vec%0d.rdata", i), rdata[0], tbl[i].exp_rdata);
    end

    // Full queue, LAT=4: req held through row 8; accepts at 0,1,4,5,8.
    fq_ok  = 13'h0133;
    fq_dok = 13'h1330;
    for (int i = 0; i < 13; i++) begin
      q = (i <= 8);
      drive(1, 1'b0, q, 1'b1, 2'd2, 32'h200, 32'h0);
      chk($sformatf("full%0d.addr_ok", i), 32'(addr_ok[1]), 32'(fq_ok[i]));
      chk($sformatf("full%0d.data_ok", i), 32'(data_ok[1]), 32'(fq_dok[i]));
      if (fq_dok[i]) chk($sformatf("full%0d.rdata", i), rdata[1], 32'h0);
    end

    // Reset with two loads outstanding, LAT=4.
    drive(1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h300, 32'h5A5A_A5A5);
    chk("rst_seq.store_ok", 32'(addr_ok[1]), 32'd1);
    repeat (5) idle(1);
    drive(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h300, 32'h0);
    chk("rst_seq.load0_ok", 32'(addr_ok[1]), 32'd1);
    drive(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h304, 32'h0);
    chk("rst_seq.load1_ok", 32'(addr_ok[1]), 32'd1);
    drive(1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("rst_seq.rst_addr_ok", 32'(addr_ok[1]), 32'd0);
    chk("rst_seq.rst_data_ok", 32'(data_ok[1]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk($sformatf("rst_seq.quiet%0d", i), 32'(data_ok[1]), 32'd0);
    end
    drive(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h300, 32'h0);
    chk("rst_seq.reload_ok", 32'(addr_ok[1]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk($sformatf("rst_seq.reload_dok%0d", i), 32'(data_ok[1]), 32'(i == 4));
      if (i == 4) chk("rst_seq.reload_rdata", rdata[1], 32'h5A5A_A5A5);
    end

    // Throughput, LAT=1: 8 stores then 8 loads back to back.
    for (int i = 0; i < 17; i++) begin
      if (i < 8)
        drive(2, 1'b0, 1'b1, 1'b1, 2'd2, 32'h400 + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111));
      else if (i < 16)
        drive(2, 1'b0, 1'b1, 1'b0, 2'd2, 32'h400 + 32'(4 * (i - 8)), 32'h0);
      else
        idle(2);
      chk($sformatf("thru%0d.addr_ok", i), 32'(addr_ok[2]), 32'(i < 16));
      chk($sformatf("thru%0d.data_ok", i), 32'(data_ok[2]), 32'(i >= 1));
      if (i >= 9)
        chk($sformatf("thru%0d.rdata", i), rdata[2], 32'h1000_0000 + 32'((i - 9) * 32'h111));
      else if (i >= 1)
        chk($sformatf("thru%0d.rdata", i), rdata[2], 32'h0);
    end
`else
    idle(0);
`endif

    random_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
